seg_scan_mux: RTL and testbench

- Parametrised multiplexed 7-segment scanner. Drives N_DIG common-select digits from a packed nibble bus.
- Adds features the earlier scanner lacks: hex/decimal glyph mode, per-digit decimal points, blank mask, leading-zero suppression, 16-level PWM brightness, selectable output polarity and frame-coherent data snapshot.
- Sits between application logic (counters, EEPROM readback, etc.) and the board segment/select pins.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg_glyph_dec.sv | 24 ++
 rtl/seg_scan_mux.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph constants and nibble-to-glyph lookup for the segment scanner
package seg_pkg;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef struct packed {
        logic       valid;
        logic [7:0] seg;
    } glyph_t;

    // Active-low glyph; nibbles above 9 are invalid (dark) outside hex mode.
    function automatic glyph_t glyph_of(input logic [3:0] nibble, input logic hex_mode);
        glyph_t g;
        g.valid = hex_mode || (nibble <= 4'd9);
        case (nibble)
            4'h0:    g.seg = GLYPH_0;
            4'h1:    g.seg = GLYPH_1;
            4'h2:    g.seg = GLYPH_2;
            4'h3:    g.seg = GLYPH_3;
            4'h4:    g.seg = GLYPH_4;
            4'h5:    g.seg = GLYPH_5;
            4'h6:    g.seg = GLYPH_6;
            4'h7:    g.seg = GLYPH_7;
            4'h8:    g.seg = GLYPH_8;
            4'h9:    g.seg = GLYPH_9;
            4'hA:    g.seg = GLYPH_A;
            4'hB:    g.seg = GLYPH_B;
            4'hC:    g.seg = GLYPH_C;
            4'hD:    g.seg = GLYPH_D;
            4'hE:    g.seg = GLYPH_E;
            default: g.seg = GLYPH_F;
        endcase
        if (!g.valid) begin
            g.seg = SEG_OFF;
        end
        return g;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// rtl/seg_glyph_dec.sv - combinational nibble decoder with decimal point and output polarity
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       dp,
    input  logic       seg_act_low,
    output logic [7:0] seg,
    output logic       valid
);

    glyph_t     g;
    logic [7:0] raw;

    // An invalid glyph still carries its decimal point.
    always_comb begin
        g     = glyph_of(nibble, hex_mode);
        raw   = g.seg & {~dp, 7'h7F};
        seg   = seg_act_low ? raw : ~raw;
        valid = g.valid;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed 7-segment scanner with PWM brightness and frame snapshot
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIG       = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic               seg_clk,
    input  logic               seg_rst,
    input  logic [4*N_DIG-1:0] dsp_data,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic [N_DIG-1:0]   blank_mask,
    input  logic               hex_mode,
    input  logic               lz_suppress,
    input  logic [3:0]         bright,
    output logic [7:0]         seg,
    output logic [N_DIG-1:0]   sel,
    output logic               frame_start
);

    localparam int SUB_N = SCAN_DIV / 16;
    localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
    localparam int IDX_W = $clog2(N_DIG);

    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(SUB_N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic             SEG_POL  = (SEG_ACT_LOW != 0);
    localparam logic             SEL_POL  = (SEL_ACT_LOW != 0);
    localparam logic [7:0]       SEG_DARK = SEG_POL ? SEG_OFF : ~SEG_OFF;
    localparam logic [7:0]       DP_ONLY  = SEG_POL ? 8'h7F : 8'h80;
    localparam logic [N_DIG-1:0] SEL_IDLE = SEL_POL ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic [SUB_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic [3:0]         pwm_ph_q, pwm_ph_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*N_DIG-1:0] data_sh_q, data_sh_d;
    logic [N_DIG-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIG-1:0]   blank_sh_q, blank_sh_d;
    logic               hex_sh_q, hex_sh_d;
    logic               lz_sh_q, lz_sh_d;
    logic [7:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   sel_q, sel_d;
    logic               frame_start_q, frame_start_d;

    logic               sub_wrap;
    logic               slot_end;
    logic               frame_end;

    always_comb begin
        sub_wrap  = (sub_cnt_q == SUB_MAX);
        slot_end  = sub_wrap && (pwm_ph_q == 4'hF);
        frame_end = slot_end && (idx_q == IDX_LAST);

        sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        pwm_ph_d  = sub_wrap ? pwm_ph_q + 4'd1 : pwm_ph_q;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        data_sh_d     = frame_end ? dsp_data    : data_sh_q;
        dp_sh_d       = frame_end ? dp_in       : dp_sh_q;
        blank_sh_d    = frame_end ? blank_mask  : blank_sh_q;
        hex_sh_d      = frame_end ? hex_mode    : hex_sh_q;
        lz_sh_d       = frame_end ? lz_suppress : lz_sh_q;
        frame_start_d = frame_end;
    end

    // Outputs are decoded from the post-edge state so seg and sel always describe the same digit.
    logic [N_DIG-1:0] supp_mask;
    logic             leading;

    always_comb begin
        supp_mask = '0;
        leading   = !hex_sh_d && lz_sh_d;
        for (int i = 0; i < N_DIG; i++) begin
            if ((data_sh_d[4*(N_DIG-1-i) +: 4] != 4'h0) && !blank_sh_d[i]) begin
                leading = 1'b0;
            end
            supp_mask[i] = leading && (i != N_DIG - 1);
        end
    end

    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             cur_blank;
    logic             cur_supp;
    logic [N_DIG-1:0] one_hot;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        one_hot   = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_nib    = data_sh_d[4*(N_DIG-1-i) +: 4];
                cur_dp     = dp_sh_d[i];
                cur_blank  = blank_sh_d[i];
                cur_supp   = supp_mask[i];
                one_hot[i] = 1'b1;
            end
        end
    end

    logic [7:0] dec_seg;
    logic       dec_valid;

    seg_glyph_dec u_glyph_dec (
        .nibble      (cur_nib),
        .hex_mode    (hex_sh_d),
        .dp          (cur_dp),
        .seg_act_low (SEG_POL),
        .seg         (dec_seg),
        .valid       (dec_valid)
    );

    logic lit;

    // A suppressed or invalid digit still lights when it carries a decimal point.
    always_comb begin
        lit   = (pwm_ph_d <= bright) && !cur_blank && ((!cur_supp && dec_valid) || cur_dp);
        seg_d = SEG_DARK;
        sel_d = SEL_IDLE;
        if (lit) begin
            seg_d = cur_supp ? DP_ONLY : dec_seg;
            sel_d = SEL_POL ? ~one_hot : one_hot;
        end
    end

    always_ff @(posedge seg_clk or posedge seg_rst) begin
        if (seg_rst) begin
            sub_cnt_q     <= SUB_MAX;
            pwm_ph_q      <= 4'hF;
            idx_q         <= IDX_LAST;
            data_sh_q     <= '0;
            dp_sh_q       <= '0;
            blank_sh_q    <= '0;
            hex_sh_q      <= 1'b0;
            lz_sh_q       <= 1'b0;
            seg_q         <= SEG_DARK;
            sel_q         <= SEL_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            sub_cnt_q     <= sub_cnt_d;
            pwm_ph_q      <= pwm_ph_d;
            idx_q         <= idx_d;
            data_sh_q     <= data_sh_d;
            dp_sh_q       <= dp_sh_d;
            blank_sh_q    <= blank_sh_d;
            hex_sh_q      <= hex_sh_d;
            lz_sh_q       <= lz_sh_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux against a frame/slot arithmetic model
`timescale 1ns/1ps
module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int SLOT  = 32;
    localparam int FRAME = ND * SLOT;
    localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dsp_data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        hex_mode;
    logic        lz_suppress;
    logic [3:0]  bright;
    logic [7:0]  seg, seg_i;
    logic [3:0]  sel, sel_i;
    logic        fs, fs_i;

    seg_scan_mux #(.N_DIG(ND), .SCAN_DIV(SLOT), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) u_dut (
        .seg_clk(clk), .seg_rst(rst), .dsp_data(dsp_data), .dp_in(dp_in),
        .blank_mask(blank_mask), .hex_mode(hex_mode), .lz_suppress(lz_suppress),
        .bright(bright), .seg(seg), .sel(sel), .frame_start(fs)
    );

    seg_scan_mux #(.N_DIG(ND), .SCAN_DIV(SLOT), .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)) u_inv (
        .seg_clk(clk), .seg_rst(rst), .dsp_data(dsp_data), .dp_in(dp_in),
        .blank_mask(blank_mask), .hex_mode(hex_mode), .lz_suppress(lz_suppress),
        .bright(bright), .seg(seg_i), .sel(sel_i), .frame_start(fs_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int p;
    int sel_on[ND];
    int idle_cnt;

    logic [15:0] snap_data;
    logic [3:0]  snap_dp, snap_blank;
    logic        snap_hex, snap_lz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at pos %0d: observed %h expected %h", tag, p, obs, expv);
        end
    endtask

    // Expected active-low display for a digit given the latched frame and live brightness.
    function automatic void model(input int dg, input int ph, output logic [7:0] es, output logic [3:0] el);
        logic [3:0] nib;
        int k;
        logic supp, valid;
        k = ND;
        for (int i = 0; i < ND; i++) begin
            nib = snap_data[4*(ND-1-i) +: 4];
            if (k == ND && nib != 0 && !snap_blank[i]) k = i;
        end
        nib   = snap_data[4*(ND-1-dg) +: 4];
        supp  = !snap_hex && snap_lz && dg < k && dg != ND - 1;
        valid = snap_hex || nib < 10;
        es = 8'hFF;
        el = 4'hF;
        if (ph <= int'(bright) && !snap_blank[dg]) begin
            if (!supp && valid) begin
                es = GLY[nib];
                if (snap_dp[dg]) es[7] = 1'b0;
                el = ~(4'b0001 << dg);
            end else if (snap_dp[dg]) begin
                es = 8'h7F;
                el = ~(4'b0001 << dg);
            end
        end
    endfunction

    task automatic step();
        logic [7:0] es;
        logic [3:0] el;
        logic       efs;
        @(posedge clk);
        p = p + 1;
        efs = (p % FRAME == 0);
        if (efs) begin
            snap_data  = dsp_data;
            snap_dp    = dp_in;
            snap_blank = blank_mask;
            snap_hex   = hex_mode;
            snap_lz    = lz_suppress;
        end
        model((p / SLOT) % ND, (p / 2) % 16, es, el);
        #1;
        chk("seg", {8'h0, seg}, {8'h0, es});
        chk("sel", {12'h0, sel}, {12'h0, el});
        chk("frame_start", {15'h0, fs}, {15'h0, efs});
        chk("seg_inv", {8'h0, seg_i}, {8'h0, ~es});
        chk("sel_inv", {12'h0, sel_i}, {12'h0, ~el});
        if (sel == 4'hF) idle_cnt++;
        for (int d = 0; d < ND; d++) begin
            if (sel == ~(4'b0001 << d)) sel_on[d]++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        idle_cnt = 0;
        for (int d = 0; d < ND; d++) sel_on[d] = 0;
    endtask

    initial begin
        rst = 1'b1;
        dsp_data = 16'h1234; dp_in = 4'h0; blank_mask = 4'h0;
        hex_mode = 1'b0; lz_suppress = 1'b0; bright = 4'hF;
        p = -1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {8'h0, seg}, 16'h00FF);
        chk("rst_sel", {12'h0, sel}, 16'h000F);
        chk("rst_fs", {15'h0, fs}, 16'h0000);
        chk("rst_seg_inv", {8'h0, seg_i}, 16'h0000);
        rst = 1'b0;

        // First edge after release is a frame boundary showing digit 0.
        step();
        chk("first_sel", {12'h0, sel}, 16'h000E);
        chk("first_seg", {8'h0, seg}, 16'h00F9);
        chk("first_fs", {15'h0, fs}, 16'h0001);
        run(FRAME - 1);
        chk("no_dead_slot", 16'(idle_cnt), 16'd0);

        dsp_data = 16'h00A5; lz_suppress = 1'b1;
        run(FRAME);
        hex_mode = 1'b1; lz_suppress = 1'b0;
        run(FRAME);
        dsp_data = 16'h0000; hex_mode = 1'b0; lz_suppress = 1'b1; dp_in = 4'b0100;
        run(FRAME);

        dsp_data = 16'h1234; dp_in = 4'h0; lz_suppress = 1'b0; bright = 4'd3;
        clear_counts();
        run(FRAME);
        for (int d = 0; d < ND; d++) chk("duty_b3", 16'(sel_on[d]), 16'd8);
        bright = 4'd0;
        clear_counts();
        run(FRAME);
        for (int d = 0; d < ND; d++) chk("duty_b0", 16'(sel_on[d]), 16'd2);

        // Mid-frame input change must wait for the next boundary.
        bright = 4'hF;
        run(SLOT + 1);
        dsp_data = 16'h9876;
        run(FRAME - SLOT - 1);
        step();
        chk("new_frame_seg", {8'h0, seg}, 16'h0090);
        run(FRAME - 1);

        blank_mask = 4'b0010;
        clear_counts();
        run(FRAME);
        chk("blank_d1", 16'(sel_on[1]), 16'd0);
        chk("blank_d0", 16'(sel_on[0]), 16'd32);
        chk("blank_d3", 16'(sel_on[3]), 16'd32);

        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < FRAME; s++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 5))
                        0: dsp_data = 16'($urandom & (32'hFFFF >> (4 * $urandom_range(0, 4))));
                        1: dp_in = 4'($urandom);
                        2: blank_mask = 4'($urandom & $urandom);
                        3: hex_mode = 1'($urandom);
                        4: lz_suppress = 1'($urandom);
                        default: bright = 4'($urandom);
                    endcase
                end
                step();
            end
        end

        // Asynchronous reset in slot 2, then restart and check the inverted-polarity build.
        blank_mask = 4'h0; dp_in = 4'h0; hex_mode = 1'b0; lz_suppress = 1'b0; bright = 4'hF;
        dsp_data = 16'h1111;
        run(FRAME - (p % FRAME) - 1);
        run(70);
        rst = 1'b1;
        #1;
        chk("async_seg", {8'h0, seg}, 16'h00FF);
        chk("async_sel", {12'h0, sel}, 16'h000F);
        chk("async_seg_inv", {8'h0, seg_i}, 16'h0000);
        chk("async_sel_inv", {12'h0, sel_i}, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("held_fs", {15'h0, fs}, 16'h0000);
        rst = 1'b0;
        p = -1;
        step();
        chk("restart_sel", {12'h0, sel}, 16'h000E);
        chk("restart_fs", {15'h0, fs}, 16'h0001);
        chk("inv_one", {8'h0, seg_i}, 16'h0006);
        chk("inv_sel", {12'h0, sel_i}, 16'h0001);
        run(FRAME - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
